// File: rtl/fp_adder.sv
// rtl/fp_adder.sv - IEEE-754 single-precision adder, multi-cycle FSM, round-to-nearest-even.
// Define FPADD_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_a_stb,
  input  logic        input_b_stb,
  input  logic        ack_output,
  input  logic        start,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  output logic        input_a_ack,
  output logic        input_b_ack,
  output logic        idle_status,
  output logic        output_valid
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1,
    NORM1, NORM2, ROUND, PACK, PUT_Z
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q, z_q;
  logic               z_stb_q, a_ack_q, b_ack_q, idle_q;
  logic [26:0]        a_m_q, b_m_q;
  logic signed [9:0]  a_e_q, b_e_q, z_e_q;
  logic [27:0]        sum_q;
  logic [23:0]        z_m_q;
  logic               z_s_q, guard_q, round_q, sticky_q;

  logic signed [9:0]  a_e_unp, b_e_unp;
  logic [26:0]        a_m_unp, b_m_unp;
  logic               a_nan, b_nan, a_inf, b_inf;
  logic [7:0]         z_bexp;

  assign a_nan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);

  assign a_e_unp = (a_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a_q[30:23]}) - 10'sd127;
  assign b_e_unp = (b_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b_q[30:23]}) - 10'sd127;

`ifdef FPADD_FTZ_EN
  assign a_m_unp = (a_q[30:23] == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
  assign b_m_unp = (b_q[30:23] == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
`else
  assign a_m_unp = {(a_q[30:23] != 8'd0), a_q[22:0], 3'b000};
  assign b_m_unp = {(b_q[30:23] != 8'd0), b_q[22:0], 3'b000};
`endif

  assign z_bexp = 8'(z_e_q + 10'sd127);

  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign idle_status  = idle_q;
  assign output_valid = (state_q == PUT_Z) && z_stb_q && ack_output;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= '0;
      z_stb_q  <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      idle_q   <= 1'b1;
      a_m_q    <= '0;
      b_m_q    <= '0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      z_e_q    <= '0;
      sum_q    <= '0;
      z_m_q    <= '0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= GET_A;
          a_ack_q <= 1'b1;
          idle_q  <= 1'b0;
        end
        GET_A: if (input_a_stb && a_ack_q) begin
          a_q     <= input_a;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b1;
          state_q <= GET_B;
        end
        GET_B: if (input_b_stb && b_ack_q) begin
          b_q     <= input_b;
          b_ack_q <= 1'b0;
          state_q <= UNPACK;
        end
        UNPACK: begin
          a_m_q   <= a_m_unp;
          b_m_q   <= b_m_unp;
          a_e_q   <= a_e_unp;
          b_e_q   <= b_e_unp;
          state_q <= SPECIAL;
        end
        SPECIAL: begin
          state_q <= PUT_Z;
          z_stb_q <= 1'b1;
          if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31])))
            z_q <= 32'h7FC00000;
          else if (a_inf)
            z_q <= a_q;
          else if (b_inf)
            z_q <= b_q;
          else if (a_m_q == 27'd0 && b_m_q == 27'd0)
            z_q <= {a_q[31] & b_q[31], 31'd0};
          else if (a_m_q == 27'd0)
            z_q <= b_q;
          else if (b_m_q == 27'd0)
            z_q <= a_q;
          else begin
            z_stb_q <= 1'b0;
            state_q <= ALIGN;
          end
        end
        // Once only the sticky bit is left, further shifts change nothing: jump the exponent.
        ALIGN: begin
          if (a_e_q > b_e_q) begin
            if (b_m_q[26:1] == 26'd0) begin
              b_e_q <= a_e_q;
            end else begin
              b_e_q <= b_e_q + 10'sd1;
              b_m_q <= {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
            end
          end else if (b_e_q > a_e_q) begin
            if (a_m_q[26:1] == 26'd0) begin
              a_e_q <= b_e_q;
            end else begin
              a_e_q <= a_e_q + 10'sd1;
              a_m_q <= {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
            end
          end else begin
            state_q <= ADD0;
          end
        end
        ADD0: begin
          z_e_q   <= a_e_q;
          state_q <= ADD1;
          if (a_q[31] == b_q[31]) begin
            sum_q <= {1'b0, a_m_q} + {1'b0, b_m_q};
            z_s_q <= a_q[31];
          end else if (a_m_q >= b_m_q) begin
            sum_q <= {1'b0, a_m_q} - {1'b0, b_m_q};
            z_s_q <= a_q[31];
          end else begin
            sum_q <= {1'b0, b_m_q} - {1'b0, a_m_q};
            z_s_q <= b_q[31];
          end
        end
        ADD1: begin
          state_q <= NORM1;
          if (sum_q == 28'd0) begin
            z_s_q    <= 1'b0;
            z_e_q    <= -10'sd126;
            z_m_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
          end else if (sum_q[27]) begin
            z_m_q    <= sum_q[27:4];
            guard_q  <= sum_q[3];
            round_q  <= sum_q[2];
            sticky_q <= sum_q[1] | sum_q[0];
            z_e_q    <= z_e_q + 10'sd1;
          end else begin
            z_m_q    <= sum_q[26:3];
            guard_q  <= sum_q[2];
            round_q  <= sum_q[1];
            sticky_q <= sum_q[0];
          end
        end
        NORM1: begin
          if (!z_m_q[23] && (z_e_q > -10'sd126)) begin
            z_e_q   <= z_e_q - 10'sd1;
            z_m_q   <= {z_m_q[22:0], guard_q};
            guard_q <= round_q;
            round_q <= 1'b0;
          end else begin
`ifdef FPADD_FTZ_EN
            state_q <= ROUND;
`else
            state_q <= NORM2;
`endif
          end
        end
        NORM2: begin
          if (z_e_q < -10'sd126) begin
            z_e_q    <= z_e_q + 10'sd1;
            z_m_q    <= {1'b0, z_m_q[23:1]};
            guard_q  <= z_m_q[0];
            round_q  <= guard_q;
            sticky_q <= sticky_q | round_q;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
            z_m_q <= z_m_q + 24'd1;
            if (z_m_q == 24'hFFFFFF)
              z_e_q <= z_e_q + 10'sd1;
          end
          state_q <= PACK;
        end
        PACK: begin
          state_q <= PUT_Z;
          z_stb_q <= 1'b1;
          if (z_e_q > 10'sd127)
            z_q <= {z_s_q, 8'hFF, 23'd0};
          else if ((z_e_q == -10'sd126) && !z_m_q[23])
`ifdef FPADD_FTZ_EN
            z_q <= {z_s_q, 31'd0};
`else
            z_q <= {z_s_q, 8'd0, z_m_q[22:0]};
`endif
          else
            z_q <= {z_s_q, z_bexp, z_m_q[22:0]};
        end
        PUT_Z: if (z_stb_q && ack_output) begin
          z_stb_q <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// tb/tb_fp_adder.sv - directed vector bench for fp_adder (expectations follow FPADD_FTZ_EN).
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = '0, input_b = '0;
  logic        input_a_stb = 1'b0, input_b_stb = 1'b0, ack_output = 1'b1, start = 1'b0;
  logic [31:0] output_z;
  logic        output_z_stb, input_a_ack, input_b_ack, idle_status, output_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[18];

  fp_adder dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_b(input_b),
    .input_a_stb(input_a_stb), .input_b_stb(input_b_stb),
    .ack_output(ack_output), .start(start),
    .output_z(output_z), .output_z_stb(output_z_stb),
    .input_a_ack(input_a_ack), .input_b_ack(input_b_ack),
    .idle_status(idle_status), .output_valid(output_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output int pulses, output logic timeout);
    bit got;
    got = 0;
    pulses = 0;
    timeout = 1'b1;
    z = '0;
    @(negedge clk);
    input_a = a; input_b = b; input_a_stb = 1'b1; input_b_stb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (output_valid) pulses++;
      if (output_z_stb && !got) begin
        z = output_z;
        got = 1;
      end
      if (got && idle_status) begin
        timeout = 1'b0;
        break;
      end
    end
    input_a_stb = 1'b0; input_b_stb = 1'b0;
  endtask

  initial begin
    logic [31:0] z, z_hold;
    int          pulses;
    logic        to;

    vecs[0]  = '{32'h433E95C3, 32'h40E80000, 32'h4345D5C3};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[5]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[6]  = '{32'h3F800000, 32'h33800001, 32'h3F800001};
`ifdef FPADD_FTZ_EN
    vecs[7]  = '{32'h00000001, 32'h00000001, 32'h00000000};
    vecs[8]  = '{32'h00800000, 32'h80000001, 32'h00800000};
`else
    vecs[7]  = '{32'h00000001, 32'h00000001, 32'h00000002};
    vecs[8]  = '{32'h00800000, 32'h80000001, 32'h007FFFFF};
`endif
    vecs[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000};
    vecs[10] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
    vecs[11] = '{32'h80000000, 32'h80000000, 32'h80000000};
    vecs[12] = '{32'h00000000, 32'h80000000, 32'h00000000};
    vecs[13] = '{32'h00000000, 32'h40490FDB, 32'h40490FDB};
    vecs[14] = '{32'h40400000, 32'hC0000000, 32'h3F800000};
    vecs[15] = '{32'h3FC00000, 32'h40100000, 32'h40700000};
    vecs[16] = '{32'h3F800000, 32'h00000001, 32'h3F800000};
    vecs[17] = '{32'h3F800000, 32'hC0000000, 32'hBF800000};

    repeat (3) @(negedge clk);
    chk("rst_z",     output_z,     32'h0);
    chk("rst_stb",   output_z_stb, 1'b0);
    chk("rst_a_ack", input_a_ack,  1'b0);
    chk("rst_b_ack", input_b_ack,  1'b0);
    chk("rst_idle",  idle_status,  1'b1);
    chk("rst_valid", output_valid, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].a, vecs[i].b, z, pulses, to);
      chk($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("vec%0d_z", i), z, vecs[i].z);
      chk($sformatf("vec%0d_pulses", i), pulses, 32'd1);
    end

    // Back-pressured result and a stalled A strobe.
    @(negedge clk);
    ack_output = 1'b0;
    input_a = 32'h433E95C3; input_b = 32'h40E80000;
    input_a_stb = 1'b0; input_b_stb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_idle_low", idle_status, 1'b0);
    chk("hold_a_ack", input_a_ack, 1'b1);
    @(negedge clk);
    chk("hold_a_ack_wait", input_a_ack, 1'b1);
    chk("hold_b_ack_wait", input_b_ack, 1'b0);
    input_a_stb = 1'b1;
    to = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (output_z_stb) begin
        to = 1'b0;
        break;
      end
    end
    chk("hold_timeout", {31'd0, to}, 32'd0);
    z_hold = output_z;
    chk("hold_z", z_hold, 32'h4345D5C3);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("hold_stb%0d", n), output_z_stb, 1'b1);
      chk($sformatf("hold_zstable%0d", n), output_z, z_hold);
      chk($sformatf("hold_novalid%0d", n), output_valid, 1'b0);
    end
    ack_output = 1'b1;
    #1;
    chk("hold_valid", output_valid, 1'b1);
    @(negedge clk);
    chk("hold_stb_clr", output_z_stb, 1'b0);
    chk("hold_idle", idle_status, 1'b1);
    chk("hold_valid_clr", output_valid, 1'b0);
    input_a_stb = 1'b0; input_b_stb = 1'b0;

    // Asynchronous reset while aligning a 24-bit exponent gap.
    @(negedge clk);
    input_a = 32'h3F800000; input_b = 32'h33800000;
    input_a_stb = 1'b1; input_b_stb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!input_a_ack && !input_b_ack && !idle_status) begin
        if (n > 0) begin
          to = 1'b0;
          break;
        end
      end
    end
    chk("arst_reach_timeout", {31'd0, to}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_idle",  idle_status,  1'b1);
    chk("arst_z",     output_z,     32'h0);
    chk("arst_stb",   output_z_stb, 1'b0);
    chk("arst_a_ack", input_a_ack,  1'b0);
    chk("arst_b_ack", input_b_ack,  1'b0);
    chk("arst_valid", output_valid, 1'b0);
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_op(32'h3F800000, 32'h3F800000, z, pulses, to);
    chk("post_rst_timeout", {31'd0, to}, 32'd0);
    chk("post_rst_z", z, 32'h40000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
